apb_rr_scheduler: RTL

APB_RR_SCHEDULER -- requirements
Module: apb_rr_scheduler

---
 rtl/apb_sched_pkg.sv | 17 +
 rtl/apb_rr_scheduler_rr_arb2.sv | 19 +
 rtl/apb_rr_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/apb_sched_pkg.sv
// Shared types and defaults for the two-requester APB scheduler.
package apb_sched_pkg;

  // Transfer FSM encoding; also exported on the debug state port.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  // Maximum ACCESS cycles spent waiting on PREADY before a transfer is abandoned.
  localparam int TIMEOUT_DEFAULT = 16;

  // PADDR bit that picks the slave: 0 = UART (PSEL0), 1 = GPIO (PSEL1).
  localparam int SEL_BIT_DEFAULT = 12;

endpackage

// File: rtl/apb_rr_scheduler_rr_arb2.sv
// Two-way round-robin choice. A lone request wins outright; when both
// requesters are present, the one that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,   // bit N = requester N has a command
  input  logic       last_i,  // index of the requester granted most recently
  output logic [1:0] gnt_o    // one-hot grant, all zero when nothing requests
);

  // Pure combinational pick; no state lives here.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && req_i[1]) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Serialises commands from two requesters onto one APB bus that reaches a
// UART (PSEL0) and a GPIO block (PSEL1), with a per-transfer PREADY timeout.
//
// Requester handshake: a command is offered by holding reqN_valid together
// with write/addr/wdata. It is taken in the cycle where reqN_ready is 1 (only
// ever while reqN_valid is 1); the command fields are captured on that edge.
// Dropping valid before ready withdraws the command. Completion is reported
// later by a one-cycle reqN_done, with reqN_err=1 meaning PREADY never came.
module apb_rr_scheduler
  import apb_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int SEL_BIT = SEL_BIT_DEFAULT
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic        PREADY0,
  input  logic        PREADY1,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;      // requester granted most recently
  logic          owner_q, owner_d;    // requester owning the current transfer
  logic          pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [CW-1:0] cnt_q, cnt_d;        // ACCESS cycles seen without PREADY
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  logic [1:0]    gnt;
  logic [1:0]    ready;
  logic          sel;
  logic          pready_sel;
  logic [31:0]   prdata_sel;
  logic          in_xfer;

  rr_arb2 u_arb (
    .req_i  ({req1_valid, req0_valid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Slave routing and handshake decode from the registered command and state.
  always_comb begin
    sel        = paddr_q[SEL_BIT];
    pready_sel = sel ? PREADY1 : PREADY0;
    prdata_sel = sel ? PRDATA1 : PRDATA0;
    in_xfer    = (state_q == SETUP) || (state_q == ACCESS);
    ready      = (state_q == IDLE && !PRESET) ? gnt : 2'b00;
  end

  // Next-state and datapath updates for the IDLE/SETUP/ACCESS sequence.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          owner_d  = 1'b0;
          last_d   = 1'b0;
          pwrite_d = req0_write;
          paddr_d  = req0_addr;
          pwdata_d = req0_wdata;
          cnt_d    = '0;
          state_d  = SETUP;
        end else if (gnt[1]) begin
          owner_d  = 1'b1;
          last_d   = 1'b1;
          pwrite_d = req1_write;
          paddr_d  = req1_addr;
          pwdata_d = req1_wdata;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_sel) begin
          state_d         = IDLE;
          done_d[owner_q] = 1'b1;
          if (!pwrite_q) begin
            if (owner_q) rdata1_d = prdata_sel;
            else         rdata0_d = prdata_sel;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Last allowed wait cycle: give up, read data is left untouched.
          state_d         = IDLE;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight without a done.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

  assign PSEL0   = in_xfer && !sel;
  assign PSEL1   = in_xfer && sel;
  assign PENABLE = (state_q == ACCESS);
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;

  assign dbg_state = state_q;

endmodule
